axi4_write_responder: RTL and testbench

AXI4_WRITE_RESPONDER -- requirements
Module: axi4_write_responder

---
 rtl/axi4_pkg.sv | 34 +++
 rtl/axi4_beat_addr_next.sv | 34 +++
 rtl/axi4_write_responder.sv | 154 +++++++++++++++
 tb/tb_axi4_write_responder.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/axi4_pkg.sv
// Shared AXI4 encodings: burst types, response codes, write-responder FSM states.
// Latency: none (types and pure functions only).
// Backpressure: not applicable.
package axi4_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10,
    BURST_RSVD  = 2'b11
  } axi4_burst_t;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } axi4_resp_t;

  typedef enum logic [1:0] {
    WR_IDLE = 2'b00,
    WR_DATA = 2'b01,
    WR_RESP = 2'b10
  } wr_state_t;

  // Bursts may not cross a 4 KB page.
  localparam int unsigned PAGE_BITS = 12;

  // WRAP bursts are legal only with 2, 4, 8 or 16 beats.
  function automatic logic wrap_len_ok(input logic [7:0] len);
    return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
  endfunction

endpackage

// File: rtl/axi4_beat_addr_next.sv
// Next beat address for FIXED / INCR / WRAP bursts; reserved bursts step as INCR.
// Latency: purely combinational.
// Backpressure: none; the caller decides when to register the result.
module axi4_beat_addr_next
  import axi4_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [2:0]            size,
  input  logic [7:0]            len,
  input  axi4_burst_t           burst,
  output logic [ADDR_WIDTH-1:0] next_addr
);

  logic [ADDR_WIDTH-1:0] step;
  logic [ADDR_WIDTH-1:0] wrap_bytes;
  logic [ADDR_WIDTH-1:0] boundary;
  logic [ADDR_WIDTH-1:0] incr_addr;

  // Step by one beat; WRAP folds back to the window base when it reaches the window end.
  always_comb begin
    step       = ADDR_WIDTH'(1) << size;
    wrap_bytes = (ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << size;
    boundary   = addr & ~(wrap_bytes - ADDR_WIDTH'(1));
    incr_addr  = addr + step;
    case (burst)
      BURST_FIXED: next_addr = addr;
      BURST_WRAP:  next_addr = (incr_addr == boundary + wrap_bytes) ? boundary : incr_addr;
      default:     next_addr = incr_addr;
    endcase
  end

endmodule

// File: rtl/axi4_write_responder.sv
// AXI4 write slave: accepts one burst at a time, emits one registered mem write per beat, then a B response.
// Latency: mem_we/addr/data/strb one cycle after each W handshake; B valid the cycle after the burst ends.
// Backpressure: AW stalls outside IDLE, W stalls outside DATA, B response held stable until bready.
module axi4_write_responder
  import axi4_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64,
  parameter int ID_WIDTH   = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [ID_WIDTH-1:0]     awid,
  input  logic [ADDR_WIDTH-1:0]   awaddr,
  input  logic [7:0]              awlen,
  input  logic [2:0]              awsize,
  input  logic [1:0]              awburst,
  input  logic                    awvalid,
  output logic                    awready,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic                    wlast,
  input  logic                    wvalid,
  output logic                    wready,
  output logic [ID_WIDTH-1:0]     bid,
  output logic [1:0]              bresp,
  output logic                    bvalid,
  input  logic                    bready,
  output logic                    mem_we,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  output logic [DATA_WIDTH/8-1:0] mem_wstrb
);

  wr_state_t             state_q, state_d;
  logic                  alive_q;
  logic [ID_WIDTH-1:0]   id_q;
  logic [ADDR_WIDTH-1:0] addr_q, addr_next;
  logic [7:0]            len_q, beat_q;
  logic [2:0]            size_q;
  axi4_burst_t           burst_q, aw_burst;
  logic                  err_cap_q, err_q;

  logic                  aw_hs, w_hs, b_hs, beat_is_len, burst_end;
  logic [ADDR_WIDTH-1:0] aw_bytes, aw_end, aw_step;
  logic                  cap_err;

  assign aw_hs       = awvalid && awready;
  assign w_hs        = wvalid && wready;
  assign b_hs        = bvalid && bready;
  assign beat_is_len = (beat_q == len_q);
  assign burst_end   = w_hs && (wlast || beat_is_len);
  assign aw_burst    = axi4_burst_t'(awburst);

  // Protocol checks on the incoming AW beat, decided once at capture.
  always_comb begin
    aw_step  = ADDR_WIDTH'(1) << awsize;
    aw_bytes = (ADDR_WIDTH'(awlen) + ADDR_WIDTH'(1)) << awsize;
    aw_end   = awaddr + aw_bytes - ADDR_WIDTH'(1);
    cap_err  = 1'b0;
    if ((32'd1 << awsize) > 32'(DATA_WIDTH / 8)) cap_err = 1'b1;
    if (aw_burst == BURST_RSVD) cap_err = 1'b1;
    if ((aw_burst == BURST_INCR) &&
        (aw_end[ADDR_WIDTH-1:PAGE_BITS] != awaddr[ADDR_WIDTH-1:PAGE_BITS])) cap_err = 1'b1;
    if ((aw_burst == BURST_WRAP) &&
        (!wrap_len_ok(awlen) || ((awaddr & (aw_step - ADDR_WIDTH'(1))) != '0))) cap_err = 1'b1;
  end

  axi4_beat_addr_next #(.ADDR_WIDTH(ADDR_WIDTH)) u_addr_next (
    .addr      (addr_q),
    .size      (size_q),
    .len       (len_q),
    .burst     (burst_q),
    .next_addr (addr_next)
  );

  // State register; alive_q keeps awready low while reset is asserted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= WR_IDLE;
      alive_q <= 1'b0;
    end else begin
      state_q <= state_d;
      alive_q <= 1'b1;
    end
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_d = state_q;
    awready = 1'b0;
    wready  = 1'b0;
    bvalid  = 1'b0;
    case (state_q)
      WR_IDLE: begin
        awready = alive_q;
        if (aw_hs) state_d = WR_DATA;
      end
      WR_DATA: begin
        wready = 1'b1;
        if (burst_end) state_d = WR_RESP;
      end
      WR_RESP: begin
        bvalid = 1'b1;
        if (b_hs) state_d = WR_IDLE;
      end
      default: state_d = WR_IDLE;
    endcase
  end

  // Burst context capture, beat tracking and registered memory write port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_q      <= '0;
      addr_q    <= '0;
      len_q     <= '0;
      size_q    <= '0;
      burst_q   <= BURST_FIXED;
      beat_q    <= '0;
      err_cap_q <= 1'b0;
      err_q     <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wstrb <= '0;
    end else begin
      mem_we <= 1'b0;
      if (aw_hs) begin
        id_q      <= awid;
        addr_q    <= awaddr;
        len_q     <= awlen;
        size_q    <= awsize;
        burst_q   <= aw_burst;
        beat_q    <= '0;
        err_cap_q <= cap_err;
        err_q     <= cap_err;
      end
      if (w_hs) begin
        addr_q    <= addr_next;
        beat_q    <= beat_q + 8'd1;
        mem_we    <= !err_cap_q;
        mem_addr  <= addr_q;
        mem_wdata <= wdata;
        mem_wstrb <= wstrb;
        // wlast must coincide exactly with beat index awlen.
        if (wlast != beat_is_len) err_q <= 1'b1;
      end
    end
  end

  assign bid   = id_q;
  assign bresp = ((state_q == WR_RESP) && err_q) ? RESP_SLVERR : RESP_OKAY;

endmodule

// File: tb/tb_axi4_write_responder.sv
// Scoreboard bench for axi4_write_responder: expected writes/responses queued at drive time, popped on output.
// Latency: checks mem writes one cycle after W handshakes and B on the handshake cycle.
// Backpressure: exercises bready stalls and back-to-back AW after B.
module tb_axi4_write_responder;

  localparam int AW = 32;
  localparam int DW = 64;
  localparam int IW = 4;

  logic          clk;
  logic          rst_n;
  logic [IW-1:0] awid;
  logic [AW-1:0] awaddr;
  logic [7:0]    awlen;
  logic [2:0]    awsize;
  logic [1:0]    awburst;
  logic          awvalid, awready;
  logic [DW-1:0] wdata;
  logic [7:0]    wstrb;
  logic          wlast, wvalid, wready;
  logic [IW-1:0] bid;
  logic [1:0]    bresp;
  logic          bvalid, bready;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [7:0]    mem_wstrb;

  axi4_write_responder #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW)) dut (
    .clk(clk), .rst_n(rst_n),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [7:0]    strb;
  } wr_t;

  typedef struct {
    logic [IW-1:0] id;
    logic [1:0]    resp;
  } b_t;

  wr_t wr_q[$];
  b_t  b_q[$];
  int  checks = 0;
  int  errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Output monitor: every mem write and B handshake must match the head of its queue.
  wr_t mon_wr;
  b_t  mon_b;
  always @(negedge clk) begin
    if (rst_n) begin
      if (awready && wready) check("aw_w_exclusive", 1, 0);
      if (mem_we) begin
        if (wr_q.size() == 0) check("mem_we_unexpected", 1, 0);
        else begin
          mon_wr = wr_q.pop_front();
          check("mem_addr", mem_addr, mon_wr.addr);
          check("mem_wdata", mem_wdata, mon_wr.data);
          check("mem_wstrb", mem_wstrb, mon_wr.strb);
        end
      end
      if (bvalid && bready) begin
        if (b_q.size() == 0) check("b_unexpected", 1, 0);
        else begin
          mon_b = b_q.pop_front();
          check("bid", bid, mon_b.id);
          check("bresp", bresp, mon_b.resp);
        end
      end
    end
  end

  // Wait (bounded) until awready or wready is seen high at a falling edge.
  task automatic wait_rdy(input bit is_w, output bit ok);
    int n = 0;
    @(negedge clk);
    while (!(is_w ? wready : awready) && n < 200) begin
      @(negedge clk);
      n++;
    end
    ok = is_w ? wready : awready;
    if (!ok) check(is_w ? "w_timeout" : "aw_timeout", 0, 1);
  endtask

  // One complete burst. wlast_at > len means wlast is never asserted.
  task automatic run_burst(input logic [IW-1:0] id, input logic [AW-1:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst, input int wlast_at,
                           input bit cap_err, input bit exp_err, input int bdelay);
    int            nbeats;
    longint        bytes, total, bnd;
    logic [DW-1:0] dat[256];
    logic [7:0]    stb[256];
    wr_t           e;
    b_t            eb;
    bit            ok;
    nbeats = (wlast_at < int'(len)) ? wlast_at + 1 : int'(len) + 1;
    bytes  = longint'(1) << size;
    total  = (longint'(len) + 1) * bytes;
    bnd    = (longint'(addr) / total) * total;
    for (int i = 0; i < nbeats; i++) begin
      dat[i] = {$urandom, $urandom};
      stb[i] = 8'($urandom);
      if (!cap_err) begin
        if (burst == 2'b00)      e.addr = addr;
        else if (burst == 2'b10) e.addr = AW'(bnd + ((longint'(addr) - bnd) + i * bytes) % total);
        else                     e.addr = AW'(longint'(addr) + i * bytes);
        e.data = dat[i];
        e.strb = stb[i];
        wr_q.push_back(e);
      end
    end
    awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
    wait_rdy(1'b0, ok);
    if (!ok) begin awvalid = 1'b0; return; end
    @(posedge clk); #1;
    awvalid = 1'b0;
    for (int i = 0; i < nbeats; i++) begin
      wvalid = 1'b1; wdata = dat[i]; wstrb = stb[i]; wlast = (i == wlast_at);
      wait_rdy(1'b1, ok);
      if (!ok) begin wvalid = 1'b0; wlast = 1'b0; return; end
      @(posedge clk); #1;
    end
    wvalid = 1'b0; wlast = 1'b0;
    eb.id = id; eb.resp = exp_err ? 2'd2 : 2'd0;
    b_q.push_back(eb);
    @(negedge clk);
    check("wready_drop", wready, 0);
    check("bvalid_up", bvalid, 1);
    for (int d = 0; d < bdelay; d++) begin
      @(negedge clk);
      check("b_hold_vld", bvalid, 1);
      check("b_hold_id", bid, id);
      check("b_hold_resp", bresp, eb.resp);
    end
    @(posedge clk); #1;
    bready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0;
    @(negedge clk);
    check("aw_after_b", awready, 1);
    @(posedge clk); #1;
  endtask

  task automatic check_reset_outputs(input string ph);
    check({ph, "_awready"}, awready, 0);
    check({ph, "_wready"}, wready, 0);
    check({ph, "_bvalid"}, bvalid, 0);
    check({ph, "_bresp"}, bresp, 0);
    check({ph, "_bid"}, bid, 0);
    check({ph, "_mem_we"}, mem_we, 0);
    check({ph, "_mem_addr"}, mem_addr, 0);
    check({ph, "_mem_wdata"}, mem_wdata, 0);
    check({ph, "_mem_wstrb"}, mem_wstrb, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    wr_t e;
    bit  ok;
    bit  saw;
    logic [DW-1:0] d;
    rst_n = 1'b0; awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("awready_idle", awready, 1);
    @(posedge clk); #1;

    //        id   addr        len size burst wlast cap  err bdly
    run_burst(4'd1, 32'h1000, 3, 3, 2'b01, 3, 0, 0, 0);   // INCR
    run_burst(4'd2, 32'h1018, 3, 3, 2'b10, 3, 0, 0, 1);   // WRAP
    run_burst(4'd3, 32'h0FF8, 1, 3, 2'b01, 1, 1, 1, 0);   // 4K crossing
    run_burst(4'd4, 32'h2000, 3, 3, 2'b01, 1, 0, 1, 5);   // early wlast, stalled B
    run_burst(4'd5, 32'h0040, 2, 3, 2'b00, 2, 0, 0, 0);   // FIXED
    run_burst(4'd6, 32'h0080, 0, 2, 2'b01, 0, 0, 0, 0);   // back-to-back single beat
    run_burst(4'd7, 32'h3000, 2, 3, 2'b10, 2, 1, 1, 0);   // WRAP bad length
    run_burst(4'd8, 32'h0100, 1, 3, 2'b11, 1, 1, 1, 0);   // reserved burst
    run_burst(4'd9, 32'h0100, 0, 4, 2'b01, 0, 1, 1, 0);   // beat wider than bus
    run_burst(4'd10, 32'h0500, 1, 3, 2'b01, 9, 0, 1, 2);  // wlast missing on final beat

    // Reset in the middle of a 4-beat INCR burst.
    awid = 4'hA; awaddr = 32'h1000; awlen = 3; awsize = 3; awburst = 2'b01; awvalid = 1'b1;
    wait_rdy(1'b0, ok);
    @(posedge clk); #1;
    awvalid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      d = {$urandom, $urandom};
      e.addr = 32'h1000 + 32'(i * 8); e.data = d; e.strb = 8'hFF;
      wr_q.push_back(e);
      wvalid = 1'b1; wdata = d; wstrb = 8'hFF; wlast = 1'b0;
      wait_rdy(1'b1, ok);
      @(posedge clk); #1;
    end
    wdata = {$urandom, $urandom};
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    wvalid = 1'b0;
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    bready = 1'b1;
    saw = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (bvalid || mem_we) saw = 1'b1;
    end
    check("no_b_after_rst", saw, 0);
    bready = 1'b0;

    check("wr_q_empty", wr_q.size(), 0);
    check("b_q_empty", b_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
